// File: rtl/wb_stage_if.sv
// wb_stage_if: bus bundle between the MEM/WB pipeline boundary and the register-file/forwarding side
//   slave  : used by wb_stage (stall inputs, MEM->WB bus, SRAM read data in; write port, forward bus, trace out)
//   master : used by the driving side (the mirror image of slave)
interface wb_stage_if;
    logic        stall_mem;
    logic        stall_wb;
    logic [74:0] mem_to_wb_bus;
    logic [31:0] data_sram_rdata;
    logic        wb_rf_we;
    logic [4:0]  wb_rf_waddr;
    logic [31:0] wb_rf_wdata;
    logic [37:0] wb_to_id_bus;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    modport slave (
        input  stall_mem, stall_wb, mem_to_wb_bus, data_sram_rdata,
        output wb_rf_we, wb_rf_waddr, wb_rf_wdata, wb_to_id_bus,
               debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );
    modport master (
        output stall_mem, stall_wb, mem_to_wb_bus, data_sram_rdata,
        input  wb_rf_we, wb_rf_waddr, wb_rf_wdata, wb_to_id_bus,
               debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: pipeline write-back stage with load data extraction, forwarding bus and commit trace
//   clk, rst : clock and synchronous active-high reset
//   wb       : wb_stage_if.slave (stalls, MEM->WB bus, SRAM rdata in; RF write port, WB->ID forward, debug trace out)
//   macro WB_DEBUG_TRACE_EN : when defined, drives the debug trace; otherwise all debug outputs are 0
module wb_stage #(
    parameter logic [31:0] PC_RESET = 32'hBFBF_FFFC
) (
    input logic       clk,
    input logic       rst,
    wb_stage_if.slave wb
);
`ifdef WB_DEBUG_TRACE_EN
    localparam logic TRACE_EN = 1'b1;
`else
    localparam logic TRACE_EN = 1'b0;
`endif
    logic        valid_q, valid_d;
    logic        committed_q, committed_d;
    logic [74:0] bus_q, bus_d;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] result;
    logic [2:0]  ld_op;
    logic [1:0]  addr_lo;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    assign rf_we    = bus_q[42];
    assign rf_waddr = bus_q[41:37];
    assign result   = bus_q[36:5];
    assign ld_op    = bus_q[4:2];
    assign addr_lo  = bus_q[1:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            committed_q <= 1'b0;
            bus_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            committed_q <= committed_d;
            bus_q       <= bus_d;
        end
    end
    // committed marks an instruction whose single write cycle has already passed while held
    always_comb begin
        valid_d     = wb.stall_wb ? valid_q : ~wb.stall_mem;
        committed_d = wb.stall_wb & (committed_q | valid_q);
        bus_d       = (wb.stall_wb | wb.stall_mem) ? bus_q : wb.mem_to_wb_bus;
    end
    always_comb begin
        ld_byte        = wb.data_sram_rdata[{addr_lo, 3'b000} +: 8];
        ld_half        = addr_lo[1] ? wb.data_sram_rdata[31:16] : wb.data_sram_rdata[15:0];
        wb.wb_rf_wdata = ld_op == 3'd1 ? {{24{ld_byte[7]}}, ld_byte} :
                         ld_op == 3'd2 ? {24'h0, ld_byte} :
                         ld_op == 3'd3 ? {{16{ld_half[15]}}, ld_half} :
                         ld_op == 3'd4 ? {16'h0, ld_half} :
                         ld_op == 3'd5 ? wb.data_sram_rdata : result;
        wb.wb_rf_we    = valid_q & rf_we & ~committed_q & (rf_waddr != 5'd0);
        wb.wb_rf_waddr = rf_waddr;
    end
    assign wb.wb_to_id_bus      = {wb.wb_rf_we, wb.wb_rf_waddr, wb.wb_rf_wdata};
    assign wb.debug_wb_pc       = TRACE_EN ? (valid_q ? bus_q[74:43] : PC_RESET) : 32'h0;
    assign wb.debug_wb_rf_wen   = TRACE_EN ? {4{wb.wb_rf_we}} : 4'h0;
    assign wb.debug_wb_rf_wnum  = TRACE_EN ? wb.wb_rf_waddr : 5'h0;
    assign wb.debug_wb_rf_wdata = TRACE_EN ? wb.wb_rf_wdata : 32'h0;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: self-checking bench for wb_stage against a behavioural write-back model
module tb_wb_stage;
    localparam logic [31:0] PC_RESET = 32'hBFBF_FFFC;
`ifdef WB_DEBUG_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    wb_stage_if ifc ();
    wb_stage #(.PC_RESET(PC_RESET)) dut (.clk(clk), .rst(rst), .wb(ifc));
    always #5 clk = ~clk;
    // model: currently held instruction and how many edges it has been held for
    bit          m_valid;
    int          m_age;
    logic [31:0] m_pc, m_result, m_rdata;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [2:0]  m_ldop;
    logic [1:0]  m_lo;
    function automatic logic [74:0] mk(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                       input logic [31:0] res, input logic [2:0] ld, input logic [1:0] lo);
        return {pc, we, wa, res, ld, lo};
    endfunction
    function automatic logic [31:0] ref_wdata();
        int b, h;
        b = int'((m_rdata >> (8 * m_lo)) & 32'hFF);
        h = int'((m_lo >= 2'd2 ? m_rdata >> 16 : m_rdata) & 32'hFFFF);
        case (m_ldop)
            3'd1: return b >= 128 ? b - 256 : b;
            3'd2: return b;
            3'd3: return h >= 32768 ? h - 65536 : h;
            3'd4: return h;
            3'd5: return m_rdata;
            default: return m_result;
        endcase
    endfunction
    function automatic logic ref_we();
        return m_valid && m_age == 0 && m_we && m_waddr != 5'd0;
    endfunction
    function automatic logic [31:0] ref_dpc();
        return TR ? (m_valid ? m_pc : PC_RESET) : 32'h0;
    endfunction
    task automatic cyc(input logic r, input logic sm, input logic sw, input logic [74:0] b, input logic [31:0] rd);
        rst = r;
        ifc.stall_mem = sm;
        ifc.stall_wb = sw;
        ifc.mem_to_wb_bus = b;
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_age = 0;
            {m_pc, m_we, m_waddr, m_result, m_ldop, m_lo} = '0;
        end else if (sw) begin
            m_age++;
        end else if (sm) begin
            m_valid = 0;
        end else begin
            m_valid = 1; m_age = 0;
            {m_pc, m_we, m_waddr, m_result, m_ldop, m_lo} = b;
        end
        #1;
        ifc.data_sram_rdata = rd;
        m_rdata = rd;
        #1;
    endtask
    task automatic test_reset();
        cyc(1, 1'b0, 1'b0, {$urandom, $urandom, $urandom}, $urandom);
        checks++; if (ifc.wb_rf_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", ifc.wb_rf_we); end
        checks++; if (ifc.wb_rf_waddr !== 5'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", ifc.wb_rf_waddr); end
        checks++; if (ifc.wb_rf_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", ifc.wb_rf_wdata); end
        checks++; if (ifc.wb_to_id_bus !== 38'h0) begin failures++; $display("FAIL reset_fwd got=%h exp=0", ifc.wb_to_id_bus); end
        checks++; if (ifc.debug_wb_rf_wen !== 4'h0) begin failures++; $display("FAIL reset_dwen got=%h exp=0", ifc.debug_wb_rf_wen); end
        checks++; if (ifc.debug_wb_pc !== (TR ? PC_RESET : 32'h0)) begin failures++; $display("FAIL reset_dpc got=%h exp=%h", ifc.debug_wb_pc, TR ? PC_RESET : 32'h0); end
    endtask
    task automatic test_alu();
        cyc(0, 1'b0, 1'b0, mk(32'h1FC0_0010, 1'b1, 5'd8, 32'h1234_5678, 3'd0, 2'd0), $urandom);
        checks++; if (ifc.wb_rf_we !== 1'b1) begin failures++; $display("FAIL alu_we got=%0b exp=1", ifc.wb_rf_we); end
        checks++; if (ifc.wb_rf_waddr !== 5'd8) begin failures++; $display("FAIL alu_waddr got=%0d exp=8", ifc.wb_rf_waddr); end
        checks++; if (ifc.wb_rf_wdata !== 32'h1234_5678) begin failures++; $display("FAIL alu_wdata got=%h exp=12345678", ifc.wb_rf_wdata); end
        checks++; if (ifc.wb_to_id_bus !== 38'h28_1234_5678) begin failures++; $display("FAIL alu_fwd got=%h exp=2812345678", ifc.wb_to_id_bus); end
        checks++; if (ifc.debug_wb_pc !== (TR ? 32'h1FC0_0010 : 32'h0)) begin failures++; $display("FAIL alu_dpc got=%h", ifc.debug_wb_pc); end
        checks++; if (ifc.debug_wb_rf_wnum !== (TR ? 5'd8 : 5'd0)) begin failures++; $display("FAIL alu_dwnum got=%0d", ifc.debug_wb_rf_wnum); end
    endtask
    task automatic test_loads();
        cyc(0, 1'b0, 1'b0, mk(32'h100, 1'b1, 5'd3, $urandom, 3'd1, 2'b10), 32'h0080_FF00);
        checks++; if (ifc.wb_rf_wdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb got=%h exp=ffffff80", ifc.wb_rf_wdata); end
        cyc(0, 1'b0, 1'b0, mk(32'h104, 1'b1, 5'd3, $urandom, 3'd2, 2'b10), 32'h0080_FF00);
        checks++; if (ifc.wb_rf_wdata !== 32'h0000_0080) begin failures++; $display("FAIL lbu got=%h exp=00000080", ifc.wb_rf_wdata); end
        cyc(0, 1'b0, 1'b0, mk(32'h108, 1'b1, 5'd3, $urandom, 3'd3, 2'b11), 32'h8001_0000);
        checks++; if (ifc.wb_rf_wdata !== 32'hFFFF_8001) begin failures++; $display("FAIL lh got=%h exp=ffff8001", ifc.wb_rf_wdata); end
        cyc(0, 1'b0, 1'b0, mk(32'h10C, 1'b1, 5'd3, $urandom, 3'd4, 2'b01), 32'h8001_9ABC);
        checks++; if (ifc.wb_rf_wdata !== 32'h0000_9ABC) begin failures++; $display("FAIL lhu got=%h exp=00009abc", ifc.wb_rf_wdata); end
        cyc(0, 1'b0, 1'b0, mk(32'h110, 1'b1, 5'd3, 32'h5555_AAAA, 3'd7, 2'b01), 32'h8001_9ABC);
        checks++; if (ifc.wb_rf_wdata !== 32'h5555_AAAA) begin failures++; $display("FAIL ldop7 got=%h exp=5555aaaa", ifc.wb_rf_wdata); end
    endtask
    task automatic test_wb_stall();
        cyc(0, 1'b0, 1'b0, mk(32'h200, 1'b1, 5'd5, 32'hCAFE_0005, 3'd0, 2'd0), $urandom);
        checks++; if (ifc.wb_rf_we !== 1'b1) begin failures++; $display("FAIL stall_first_we got=%0b exp=1", ifc.wb_rf_we); end
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1'b1, 1'b1, mk(32'h300, 1'b1, 5'd9, 32'h1111_1111, 3'd0, 2'd0), $urandom);
            checks++; if (ifc.wb_rf_we !== 1'b0) begin failures++; $display("FAIL stall_held_we cyc=%0d got=%0b exp=0", i, ifc.wb_rf_we); end
            checks++; if ({ifc.wb_rf_waddr, ifc.wb_rf_wdata} !== {5'd5, 32'hCAFE_0005}) begin failures++; $display("FAIL stall_held_reg cyc=%0d got=%0d/%h exp=5/cafe0005", i, ifc.wb_rf_waddr, ifc.wb_rf_wdata); end
            checks++; if (ifc.debug_wb_pc !== (TR ? 32'h200 : 32'h0)) begin failures++; $display("FAIL stall_held_dpc cyc=%0d got=%h", i, ifc.debug_wb_pc); end
        end
        cyc(0, 1'b0, 1'b0, mk(32'h204, 1'b1, 5'd6, 32'h6, 3'd0, 2'd0), $urandom);
        checks++; if ({ifc.wb_rf_we, ifc.wb_rf_waddr} !== {1'b1, 5'd6}) begin failures++; $display("FAIL stall_release got=%0b/%0d exp=1/6", ifc.wb_rf_we, ifc.wb_rf_waddr); end
    endtask
    task automatic test_bubble();
        cyc(0, 1'b0, 1'b0, mk(32'h400, 1'b1, 5'd9, 32'h9, 3'd0, 2'd0), $urandom);
        cyc(0, 1'b1, 1'b0, mk(32'h404, 1'b1, 5'd10, 32'hA, 3'd0, 2'd0), $urandom);
        checks++; if (ifc.wb_rf_we !== 1'b0) begin failures++; $display("FAIL bubble_we got=%0b exp=0", ifc.wb_rf_we); end
        checks++; if (ifc.debug_wb_pc !== (TR ? PC_RESET : 32'h0)) begin failures++; $display("FAIL bubble_dpc got=%h exp=%h", ifc.debug_wb_pc, TR ? PC_RESET : 32'h0); end
        cyc(0, 1'b0, 1'b0, mk(32'h408, 1'b1, 5'd0, 32'hDEAD, 3'd0, 2'd0), $urandom);
        checks++; if (ifc.wb_rf_we !== 1'b0) begin failures++; $display("FAIL r0_we got=%0b exp=0", ifc.wb_rf_we); end
        checks++; if (ifc.wb_to_id_bus[37] !== 1'b0) begin failures++; $display("FAIL r0_fwd_we got=%0b exp=0", ifc.wb_to_id_bus[37]); end
    endtask
    task automatic test_reset_mid_stall();
        cyc(0, 1'b0, 1'b0, mk(32'h500, 1'b1, 5'd7, 32'h7777, 3'd0, 2'd0), $urandom);
        cyc(1, 1'b1, 1'b1, mk(32'h504, 1'b1, 5'd7, 32'h7777, 3'd0, 2'd0), $urandom);
        checks++; if ({ifc.wb_rf_we, ifc.wb_rf_waddr, ifc.wb_rf_wdata} !== 38'h0) begin failures++; $display("FAIL rst_stall_port got=%h exp=0", {ifc.wb_rf_we, ifc.wb_rf_waddr, ifc.wb_rf_wdata}); end
        checks++; if (ifc.debug_wb_pc !== (TR ? PC_RESET : 32'h0)) begin failures++; $display("FAIL rst_stall_dpc got=%h", ifc.debug_wb_pc); end
        cyc(0, 1'b1, 1'b1, mk(32'h508, 1'b1, 5'd7, 32'h7777, 3'd0, 2'd0), $urandom);
        checks++; if (ifc.wb_rf_we !== 1'b0) begin failures++; $display("FAIL rst_stall_after_we got=%0b exp=0", ifc.wb_rf_we); end
    endtask
    task automatic test_random();
        logic sm, sw, r;
        logic [4:0] wa;
        for (int i = 0; i < 400; i++) begin
            sw = ($urandom % 4) == 0;
            sm = sw | (($urandom % 4) == 0);
            r  = ($urandom % 50) == 0;
            wa = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
            cyc(r, sm, sw, mk($urandom, 1'($urandom), wa, $urandom, 3'($urandom), 2'($urandom)), $urandom);
            checks++; if (ifc.wb_rf_we !== ref_we()) begin failures++; $display("FAIL rnd_we i=%0d got=%0b exp=%0b", i, ifc.wb_rf_we, ref_we()); end
            checks++; if (ifc.debug_wb_pc !== ref_dpc()) begin failures++; $display("FAIL rnd_dpc i=%0d got=%h exp=%h", i, ifc.debug_wb_pc, ref_dpc()); end
            checks++; if (ifc.debug_wb_rf_wen !== (TR ? {4{ref_we()}} : 4'h0)) begin failures++; $display("FAIL rnd_dwen i=%0d got=%h", i, ifc.debug_wb_rf_wen); end
            if (m_valid) begin
                checks++; if (ifc.wb_to_id_bus !== {ref_we(), m_waddr, ref_wdata()}) begin failures++; $display("FAIL rnd_fwd i=%0d got=%h exp=%h", i, ifc.wb_to_id_bus, {ref_we(), m_waddr, ref_wdata()}); end
                checks++; if ({ifc.wb_rf_waddr, ifc.wb_rf_wdata} !== {m_waddr, ref_wdata()}) begin failures++; $display("FAIL rnd_port i=%0d got=%0d/%h exp=%0d/%h", i, ifc.wb_rf_waddr, ifc.wb_rf_wdata, m_waddr, ref_wdata()); end
                checks++; if (ifc.debug_wb_rf_wdata !== (TR ? ref_wdata() : 32'h0)) begin failures++; $display("FAIL rnd_dwdata i=%0d got=%h", i, ifc.debug_wb_rf_wdata); end
            end
        end
    endtask
    initial begin
        rst = 1'b1;
        ifc.stall_mem = 1'b0;
        ifc.stall_wb = 1'b0;
        ifc.mem_to_wb_bus = '0;
        ifc.data_sram_rdata = '0;
        test_reset();
        test_alu();
        test_loads();
        test_wb_stall();
        test_bubble();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'hBFBF_FFFC, the value of debug_wb_pc while no instruction is held.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port stall_mem  in  1  MEM stage stalled, so no new instruction is offered this cycle.
REQ-005 SHALL have port stall_wb  in  1  WB stage stalled, so the stage holds its contents; stall_wb=1 implies stall_mem=1.
REQ-006 SHALL have port mem_to_wb_bus  in  75  fields {pc[74:43], rf_we[42], rf_waddr[41:37], result[36:5], ld_op[4:2], addr_lo[1:0]}.
REQ-007 SHALL have port data_sram_rdata  in  32  load word returned by the synchronous data SRAM during the WB cycle.
REQ-008 SHALL have port wb_rf_we  out  1  register file write enable.
REQ-009 SHALL have port wb_rf_waddr  out  5  register file write address.
REQ-010 SHALL have port wb_rf_wdata  out  32  register file write data.
REQ-011 SHALL have port wb_to_id_bus  out  38  forwarding bus {we[37], waddr[36:32], wdata[31:0]}, same layout as the EX forwarding bus.
REQ-012 SHALL have ports debug_wb_pc (out, 32), debug_wb_rf_wen (out, 4), debug_wb_rf_wnum (out, 5) and debug_wb_rf_wdata (out, 32), the commit trace.

Function
REQ-013 SHALL capture mem_to_wb_bus into a WB register and set valid=1 on each edge where stall_mem=0 and stall_wb=0.
REQ-014 SHALL clear valid (bubble) on an edge where stall_mem=1 and stall_wb=0.
REQ-015 SHALL hold the WB register unchanged on an edge where stall_wb=1.
REQ-016 SHALL keep a committed flag: set on the edge after a cycle with valid=1 and stall_wb=1, cleared whenever the register loads or bubbles.
REQ-017 SHALL drive wb_rf_we = valid & rf_we & ~committed & (rf_waddr!=0), so each instruction writes exactly once under any stall length.
REQ-018 SHALL make wb_rf_wdata combinational on the held register and data_sram_rdata, giving zero added latency within the WB cycle.
REQ-019 SHALL select wb_rf_wdata by ld_op: 000 result; 001 lb, sign-extended byte at addr_lo; 010 lbu, zero-extended byte; 011 lh, sign-extended halfword at addr_lo[1]; 100 lhu, zero-extended halfword; 101 lw, full word; 110/111 treated as 000.
REQ-020 SHALL make lh/lhu ignore addr_lo[0]; the misaligned exception is raised upstream, not here.
REQ-021 SHALL drive wb_to_id_bus = {wb_rf_we, wb_rf_waddr, wb_rf_wdata}, identical to the write port in every cycle.
REQ-022 SHALL give precedence to the EX forward over this bus when both target the same register; the ID-side mux owns that ordering and this block does not arbitrate it.
REQ-023 SHALL drive debug_wb_rf_wen = {4{wb_rf_we}}, debug_wb_rf_wnum = wb_rf_waddr, debug_wb_rf_wdata = wb_rf_wdata, and debug_wb_pc = pc when valid, else PC_RESET.

Reset
REQ-024 SHALL, on rst=1 at an edge, clear valid, committed and all register fields to 0, regardless of stall inputs.
REQ-025 SHALL, in the cycle after reset, output wb_rf_we=0, wb_rf_waddr=0, wb_rf_wdata=0 (ld_op=000, result=0), wb_to_id_bus=0, debug_wb_rf_wen=0 and debug_wb_pc=PC_RESET.
REQ-026 SHALL drop a pending uncommitted write when reset is asserted mid-stall.

Configuration
REQ-027 SHALL, with macro WB_DEBUG_TRACE_EN defined, drive the debug outputs per REQ-023.
REQ-028 SHALL, without WB_DEBUG_TRACE_EN, tie all debug outputs to 0, including debug_wb_pc; the write port and forwarding behaviour are unchanged.

Verification
REQ-029 SHALL cover ALU write: bus with rf_we=1, waddr=5'd8, result=32'h1234_5678, ld_op=000 -> next cycle wb_rf_we=1, waddr=8, wdata=32'h1234_5678, wb_to_id_bus=38'h28_1234_5678.
REQ-030 SHALL cover lb: ld_op=001, addr_lo=2'b10, data_sram_rdata=32'h0080_FF00 -> wdata=32'hFFFF_FF80; the same with lbu -> 32'h0000_0080.
REQ-031 SHALL cover lh: ld_op=011, addr_lo=2'b11, rdata=32'h8001_0000 -> wdata=32'hFFFF_8001 (addr_lo[0] ignored).
REQ-032 SHALL cover a WB stall held 3 cycles on a write to r5 -> wb_rf_we=1 in the first cycle only, 0 in the next two, and the WB register unchanged throughout.
REQ-033 SHALL cover stall_mem=1 with stall_wb=0 -> bubble next cycle: wb_rf_we=0 and debug_wb_pc=PC_RESET; a write to r0 -> wb_rf_we=0.
REQ-034 SHALL cover rst=1 asserted during a WB stall with a pending write -> next cycle all outputs are at reset values and no write occurs.
